servo_slew_limiter: RTL
=======================

Name: servo_slew_limiter

Overview:
- Sits between keyboardControl and each pwm instance; one per joint (shoulder, elbow, base).
- Takes the raw commanded pulse width (angle, in clk counts) and produces a rate-limited, range-clamped pulse width for the pwm block.
- Prevents servo snap and brown-out on large keyboard jumps.
- Moves the output toward the target by at most STEP counts every TICK_DIV clock cycles.

Parameters:
- WIDTH, 24, width of angle values (matches pwm angle input).
- TICK_DIV, 100000, clk cycles per slew step (1 ms at 100 MHz).
- STEP, 1000, max change of angle_out per step, in counts.
- MIN_ANGLE, 100000, lower clamp (1.0 ms pulse).
- MAX_ANGLE, 200000, upper clamp (2.0 ms pulse).
- HOME_ANGLE, 150000, reset value of angle_out; must lie within [MIN_ANGLE, MAX_ANGLE].
- STEP_MAX, 8000, accel ceiling; used only with the optional feature.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-low reset.
- target, input, WIDTH, raw commanded angle from keyboardControl; sampled every cycle.
- freeze, input, 1, when 1: tick counter and angle_out hold, FSM holds state.
- angle_out, output, WIDTH, rate-limited angle to pwm.
- busy, output, 1, 1 while in RAMP_UP or RAMP_DOWN.
- at_target, output, 1, 1 when angle_out equals the clamped target.
- clamped, output, 1, 1 when the last sampled target was outside [MIN_ANGLE, MAX_ANGLE].

Behaviour:
- Reset (reset=0, async):
  - angle_out=HOME_ANGLE, target_q=HOME_ANGLE, tick counter=0, state=IDLE.
  - busy=0, at_target=1, clamped=0, current step=STEP.
- Input stage, registered, 1-cycle latency:
  - target_q <= clamp(target, MIN_ANGLE, MAX_ANGLE).
  - clamped <= (target<MIN_ANGLE) | (target>MAX_ANGLE).
  - Compares are unsigned.
- Difference: computed in WIDTH+1 bits. diff = target_q - angle_out; sign selects direction. No wrap is allowed.
- FSM states: IDLE, RAMP_UP, RAMP_DOWN.
  - IDLE:
    - tick counter held at 0.
    - target_q>angle_out -> RAMP_UP.
    - target_q<angle_out -> RAMP_DOWN.
    - equal -> stay.
  - RAMP_*:
    - Tick counter counts 0..TICK_DIV-1 and wraps.
    - On the cycle the counter equals TICK_DIV-1 (the step cycle), one update occurs.
    - If |diff| <= step: angle_out <= target_q, next state IDLE.
    - Otherwise angle_out moves by step toward target_q.
  - Direction reversal mid-ramp (target_q crosses angle_out): go directly RAMP_UP<->RAMP_DOWN. The counter is not reset.
  - Target change in RAMP without reversal: keep state and counter; the new target_q is used at the next step.
- First step lands TICK_DIV cycles after the IDLE->RAMP transition.
- angle_out is never outside [MIN_ANGLE, MAX_ANGLE] and never overshoots target_q.
- busy = (state != IDLE).
- at_target = (angle_out == target_q), registered, updated the same cycle as angle_out.
- freeze=1:
  - All state holds.
  - The input stage still samples, and clamped still updates.
  - Freeze coincident with a step cycle suppresses that step.
- Reset mid-ramp: immediate return to reset values; no partial step.

Optional Feature:
- Macro: SLEW_ACCEL_EN.
- Defined:
  - The current step starts at STEP on IDLE->RAMP.
  - It doubles after each non-final step, saturating at STEP_MAX.
  - It resets to STEP on a direction reversal or on return to IDLE.
  - The |diff| <= step snap rule uses the current step.
- Undefined: step is constantly STEP and STEP_MAX is unused.

Test Plan:
All tests use TICK_DIV=4, STEP=10, MIN=100, MAX=200, HOME=150.
- Reset: release reset with target=150 -> angle_out=150, busy=0, at_target=1, clamped=0.
- Up ramp: target=175 -> busy rises 2 cycles later; angle_out goes 160, 170, 175 at 4-cycle intervals; busy falls and at_target=1 on the 175 update.
- Clamp: target=250 -> clamped=1 next cycle; angle_out ramps to and stops at 200. Then target=40 -> ramps down and stops at 100.
- Reversal: from 150, target=200. After angle_out=170, set target=155 -> state RAMP_DOWN with no counter restart; next steps 160, then 155.
- Freeze / reset: mid-ramp, freeze=1 for 10 cycles -> angle_out constant, counter held. Resume continues the ramp. Asserting reset mid-ramp -> angle_out=150 asynchronously.
- SLEW_ACCEL_EN (STEP_MAX=40): 100->200 -> angle_out 110, 130, 170, then 200 as the snap step (diff 30 <= 40).

Source files
------------

// File: rtl/servo_slew_limiter_if.sv
// Command/status bundle between keyboardControl and one servo_slew_limiter.
// The master drives target/freeze; the slave (limiter) returns the slewed angle and status.
interface servo_slew_limiter_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] target;
  logic             freeze;
  logic [WIDTH-1:0] angle_out;
  logic             busy;
  logic             at_target;
  logic             clamped;

  modport master (
    output target, freeze,
    input  angle_out, busy, at_target, clamped
  );

  modport slave (
    input  target, freeze,
    output angle_out, busy, at_target, clamped
  );
endinterface

// File: rtl/servo_slew_limiter.sv
// Rate limiter and range clamp for one servo joint's pulse width.
// Optional macro SLEW_ACCEL_EN: the step doubles each non-final step, saturating at STEP_MAX.
module servo_slew_limiter #(
  parameter int WIDTH      = 24,
  parameter int TICK_DIV   = 100000,
  parameter int STEP       = 1000,
  parameter int MIN_ANGLE  = 100000,
  parameter int MAX_ANGLE  = 200000,
  parameter int HOME_ANGLE = 150000,
  parameter int STEP_MAX   = 8000
) (
  input  logic                clk,
  input  logic                reset,
  servo_slew_limiter_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] MIN_A     = WIDTH'(MIN_ANGLE);
  localparam logic [WIDTH-1:0] MAX_A     = WIDTH'(MAX_ANGLE);
  localparam logic [WIDTH-1:0] HOME_A    = WIDTH'(HOME_ANGLE);
  localparam logic [WIDTH-1:0] STEP_A    = WIDTH'(STEP);

  if (HOME_ANGLE < MIN_ANGLE || HOME_ANGLE > MAX_ANGLE || MIN_ANGLE > MAX_ANGLE ||
      STEP_MAX < STEP || TICK_DIV < 1) begin : g_bad_param
    $error("servo_slew_limiter: inconsistent parameters");
  end

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] clamp_angle(input logic [WIDTH-1:0] v);
    if (v < MIN_A) begin
      return MIN_A;
    end else if (v > MAX_A) begin
      return MAX_A;
    end else begin
      return v;
    end
  endfunction

  state_t           state_r, state_n;
  logic [TW-1:0]    tick_r, tick_n;
  logic [WIDTH-1:0] angle_r, angle_n;
  logic [WIDTH-1:0] step_r, step_n;
  logic [WIDTH-1:0] target_q_r;
  logic             clamped_r;
  logic             busy_r;
  logic             at_target_r;

  logic [WIDTH-1:0] target_clamped_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH:0]   abs_s;
  logic             up_s, down_s, rev_s, snap_s, step_cycle_s;
  logic [WIDTH-1:0] step_grow_s;

  assign target_clamped_s = clamp_angle(bus.target);

  // Direction and magnitude from a WIDTH+1 bit difference so it never wraps.
  assign diff_s       = {1'b0, target_q_r} - {1'b0, angle_r};
  assign down_s       = diff_s[WIDTH];
  assign up_s         = !diff_s[WIDTH] && (diff_s != '0);
  assign abs_s        = diff_s[WIDTH] ? (~diff_s + {{WIDTH{1'b0}}, 1'b1}) : diff_s;
  assign snap_s       = (abs_s <= {1'b0, step_r});
  assign step_cycle_s = (tick_r == TICK_LAST);
  assign rev_s        = ((state_r == ST_RAMP_UP) && down_s) ||
                        ((state_r == ST_RAMP_DOWN) && up_s);

`ifdef SLEW_ACCEL_EN
  logic [WIDTH:0] step_dbl_s;
  assign step_dbl_s  = {step_r, 1'b0};
  assign step_grow_s = (step_dbl_s > (WIDTH+1)'(STEP_MAX)) ? WIDTH'(STEP_MAX)
                                                           : step_dbl_s[WIDTH-1:0];
`else
  assign step_grow_s = STEP_A;
`endif

  // Input stage: clamp and flag the raw target; keeps sampling while frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_q_r <= HOME_A;
      clamped_r  <= 1'b0;
    end else begin
      target_q_r <= target_clamped_s;
      clamped_r  <= (bus.target < MIN_A) || (bus.target > MAX_A);
    end
  end

  // Next-state, tick counter and angle update.
  always_comb begin
    state_n = state_r;
    tick_n  = tick_r;
    angle_n = angle_r;
    step_n  = step_r;
    if (!bus.freeze) begin
      case (state_r)
        ST_IDLE: begin
          tick_n = '0;
          step_n = STEP_A;
          if (up_s) begin
            state_n = ST_RAMP_UP;
          end else if (down_s) begin
            state_n = ST_RAMP_DOWN;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_RAMP_UP, ST_RAMP_DOWN: begin
          if (step_cycle_s) begin
            tick_n = '0;
            if (snap_s) begin
              angle_n = target_q_r;
              state_n = ST_IDLE;
              step_n  = STEP_A;
            end else begin
              angle_n = down_s ? (angle_r - step_r) : (angle_r + step_r);
              state_n = down_s ? ST_RAMP_DOWN : ST_RAMP_UP;
              step_n  = rev_s ? STEP_A : step_grow_s;
            end
          end else begin
            tick_n = tick_r + TW'(1);
            // A reversal swaps direction without restarting the tick phase.
            if (rev_s) begin
              state_n = down_s ? ST_RAMP_DOWN : ST_RAMP_UP;
              step_n  = STEP_A;
            end else begin
              state_n = state_r;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          tick_n  = '0;
          step_n  = STEP_A;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Ramp state and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      tick_r      <= '0;
      angle_r     <= HOME_A;
      step_r      <= STEP_A;
      busy_r      <= 1'b0;
      at_target_r <= 1'b1;
    end else begin
      state_r     <= state_n;
      tick_r      <= tick_n;
      angle_r     <= angle_n;
      step_r      <= step_n;
      busy_r      <= (state_n != ST_IDLE);
      at_target_r <= (angle_n == target_clamped_s);
    end
  end

  assign bus.angle_out = angle_r;
  assign bus.busy      = busy_r;
  assign bus.at_target = at_target_r;
  assign bus.clamped   = clamped_r;

endmodule
